// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: state
// encoding, default sizing and the minimum-digit helper used to reject
// undersized configurations at elaboration.
package bcd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_DIGITS = 3;

    // Number of decimal digits needed to show 2^width-1.
    function automatic int min_digits(input int width);
        longint unsigned maxv;
        int              n;
        maxv = (64'd1 << width) - 64'd1;
        n    = 1;
        for (int i = 0; i < 20; i++) begin
            if (maxv >= 64'd10) begin
                maxv = maxv / 64'd10;
                n    = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: add-3 correction on every BCD digit that is
// 5 or more, then a 1-bit left shift of {acc, sr}. Purely combinational.
module dabble_step #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] acc,
    input  logic [WIDTH-1:0]    sr,
    output logic [4*DIGITS-1:0] acc_next,
    output logic [WIDTH-1:0]    sr_next
);

    localparam int BW = 4 * DIGITS;

    logic [BW-1:0] corr;
    // The top bit of the corrected scratch falls off the shift; for legal
    // inputs it is always zero.
    logic          unused_msb;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            // Digits of 5..9 would carry past 9 after doubling; pre-add 3.
            always_comb begin
                if (acc[4*gi +: 4] >= 4'd5) begin
                    corr[4*gi +: 4] = acc[4*gi +: 4] + 4'd3;
                end else begin
                    corr[4*gi +: 4] = acc[4*gi +: 4];
                end
            end
        end
    endgenerate

    assign {unused_msb, acc_next, sr_next} = {corr, sr, 1'b0};

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock,
// with a start/busy/done handshake. The result register holds the last
// conversion until the next one completes.
// Optional build macro BCD_AUTO_START_EN: restarts a conversion on its own
// whenever the input differs from the last accepted value (and once after
// reset), so the output tracks bin without an external start.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    bin,
    input  logic                start,
    output logic [4*DIGITS-1:0] bcd,
    output logic                busy,
    output logic                done
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("bin_to_bcd_seq: WIDTH must be 1..16");
        end
        if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t          state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [BW-1:0]   acc_reg, acc_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [BW-1:0]   bcd_reg, bcd_next;
    logic            done_reg, done_next;

    logic [BW-1:0]   step_acc;
    logic [WIDTH-1:0] step_sr;

    logic            go;
    logic [WIDTH-1:0] load_val;

    dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .acc      (acc_reg),
        .sr       (sr_reg),
        .acc_next (step_acc),
        .sr_next  (step_sr)
    );

`ifdef BCD_AUTO_START_EN
    logic [WIDTH-1:0] bin_q_reg;
    logic [WIDTH-1:0] last_reg;
    logic             first_reg;

    // Sample bin every cycle and remember what the last conversion used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q_reg <= '0;
            last_reg  <= '0;
            first_reg <= 1'b1;
        end else begin
            bin_q_reg <= bin;
            first_reg <= 1'b0;
            if (state_reg == ST_IDLE && go) begin
                last_reg <= load_val;
            end
        end
    end

    // An explicit start loads the live input; a self-start loads the sample.
    always_comb begin
        go       = start || first_reg || (bin_q_reg != last_reg);
        load_val = start ? bin : bin_q_reg;
    end
`else
    // Conversions begin only on the external request.
    always_comb begin
        go       = start;
        load_val = bin;
    end
`endif

    // Next-state and datapath selection for the IDLE/SHIFT controller.
    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        bcd_next   = bcd_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (go) begin
                    sr_next    = load_val;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_next  = step_sr;
                acc_next = step_acc;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    bcd_next   = step_acc;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sr_reg    <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            bcd_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            bcd_reg   <= bcd_next;
            done_reg  <= done_next;
        end
    end

    assign bcd  = bcd_reg;
    assign done = done_reg;
    assign busy = (state_reg == ST_SHIFT);

endmodule
